bf_out_uart: RTL and testbench

BF_OUT_UART -- requirements
Module: bf_out_uart

---
 rtl/bf_out_uart.sv | 150 +++++++++++++++
 tb/tb_bf_out_uart.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_out_uart.sv
// Byte FIFO in front of an 8N1 UART transmitter for the processor's '.' output.
// A write into an idle, empty block is popped on the next edge, with no bypass path.
module bf_out_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] out_data,
    input  logic       out_valid,
    output logic       out_ready,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       busy,
    output logic [3:0] count,
    output logic       overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [7:0]    LAST_CNT = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    FULL_CNT = 4'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic [7:0]    bit_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic full;
    logic bit_last;
    logic pop;
    logic wr_en;
    logic drop;

    assign full     = (count == FULL_CNT);
    assign bit_last = (bit_cnt == LAST_CNT);
    // A pop happens when the line is free: from IDLE, or on the last STOP cycle.
    assign pop      = (count != 4'd0) && ((state == IDLE) || (state == STOP && bit_last));
    assign wr_en    = out_valid && (!full || pop);
    assign drop     = out_valid && full && !pop;

    assign out_ready = (count < FULL_CNT);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= out_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            // A drop wins over a same-edge clear so no lost byte goes unreported.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // tx is loaded with the level of the state being entered, so it never glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= 8'd0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            tx      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift   <= mem[rd_ptr];
                        bit_cnt <= 8'd0;
                        state   <= START;
                        tx      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_last) begin
                        bit_cnt <= 8'd0;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_last) begin
                        bit_cnt <= 8'd0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                default: begin
                    if (bit_last) begin
                        bit_cnt <= 8'd0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_out_uart.sv
// Directed bench for bf_out_uart at CLKS_PER_BIT=4, DEPTH=8, with an independent
// line receiver that decodes tx into bytes and frame start times.
module tb_bf_out_uart;

    logic       clock;
    logic       reset;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       clr_ovf;
    logic       tx;
    logic       busy;
    logic [3:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    bf_out_uart #(.CLKS_PER_BIT(4), .DEPTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .clr_ovf(clr_ovf),
        .tx(tx),
        .busy(busy),
        .count(count),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Receiver: s counts samples from the first start-bit cycle; bit centres at 4*b+2.
    int         cyc = 0;
    bit         rx_on = 1'b0;
    int         rx_s = 0;
    logic [7:0] rx_sh = 8'd0;
    int         rx_ferr = 0;
    logic [7:0] rx_bytes[$];
    int         rx_start[$];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_on = 1'b0;
            rx_s  = 0;
        end else begin
            cyc = cyc + 1;
            if (!rx_on) begin
                if (tx == 1'b0) begin
                    rx_on = 1'b1;
                    rx_s  = 1;
                    rx_start.push_back(cyc);
                end
            end else begin
                if (rx_s >= 6 && rx_s <= 34 && ((rx_s - 2) % 4) == 0) begin
                    rx_sh[(rx_s - 6) / 4] = tx;
                end
                if (rx_s == 38) begin
                    rx_bytes.push_back(rx_sh);
                    if (tx !== 1'b1) rx_ferr = rx_ferr + 1;
                end
                if (rx_s == 39) rx_on = 1'b0;
                else rx_s = rx_s + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_errors = n_errors + 1;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int max_cycles, output int waited);
        waited = 0;
        while (busy === 1'b1 && waited < max_cycles) begin
            tick();
            waited = waited + 1;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    initial begin
        logic [7:0] b;
        int         e1;
        int         waited;
        int         base;
        int         starts;
        int         exp_tx;
        int         idx;

        reset     = 1'b1;
        out_data  = 8'd0;
        out_valid = 1'b0;
        clr_ovf   = 1'b0;
        #1;
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_ready", 32'(out_ready), 1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Single byte 0x41: count is 1 for one cycle, then a 40-cycle frame.
        b         = 8'h41;
        out_data  = b;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        check("single_count_wr", 32'(count), 1);
        check("single_busy_wr", 32'(busy), 0);
        check("single_tx_wr", 32'(tx), 1);
        tick();
        check("single_count_pop", 32'(count), 0);
        check("single_busy_pop", 32'(busy), 1);
        for (int k = 0; k < 40; k++) begin
            if (k < 4) exp_tx = 0;
            else if (k < 36) exp_tx = 32'(b[(k - 4) / 4]);
            else exp_tx = 1;
            check("single_tx_bit", 32'(tx), 32'(exp_tx));
            check("single_busy_frame", 32'(busy), 1);
            tick();
        end
        check("single_busy_end", 32'(busy), 0);
        check("single_tx_end", 32'(tx), 1);
        check("single_count_end", 32'(count), 0);
        check("single_rx_byte", 32'(rx_bytes[rx_bytes.size() - 1]), 32'h41);

        // Burst 0x00..0x09: first byte pops at E1, so 0x09 finds the FIFO full.
        base   = rx_bytes.size();
        starts = rx_start.size();
        e1     = 0;
        for (int i = 0; i < 10; i++) begin
            out_data  = 8'(i);
            out_valid = 1'b1;
            tick();
            if (i == 1) e1 = cyc;
        end
        out_valid = 1'b0;
        check("burst_count", 32'(count), 8);
        check("burst_ovf", 32'(overflow), 1);
        check("burst_ready", 32'(out_ready), 0);
        clr_ovf = 1'b1;
        tick();
        check("clr_ovf", 32'(overflow), 0);
        out_data  = 8'hEE;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        check("clr_with_drop_ovf", 32'(overflow), 1);
        check("clr_with_drop_count", 32'(count), 8);
        tick();
        clr_ovf = 1'b0;
        check("clr_again_ovf", 32'(overflow), 0);
        wait_idle(600, waited);
        check("burst_duration", 32'(cyc - e1), 360);
        check("burst_frames", 32'(rx_bytes.size() - base), 9);
        for (int i = 0; i < 9; i++) begin
            if (base + i < rx_bytes.size()) check("burst_byte", 32'(rx_bytes[base + i]), 32'(i));
        end
        for (int i = 1; i < 9; i++) begin
            if (starts + i < rx_start.size())
                check("burst_gap", 32'(rx_start[starts + i] - rx_start[starts + i - 1]), 40);
        end

        // Full FIFO plus a write on the edge that ends the first STOP.
        base = rx_bytes.size();
        for (int i = 0; i < 9; i++) begin
            out_data  = 8'(8'h10 + i);
            out_valid = 1'b1;
            tick();
        end
        out_valid = 1'b0;
        check("full_count", 32'(count), 8);
        repeat (32) tick();
        out_data  = 8'h5A;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        check("fullpop_count", 32'(count), 8);
        check("fullpop_ovf", 32'(overflow), 0);
        check("fullpop_busy", 32'(busy), 1);
        wait_idle(800, waited);
        check("fullpop_frames", 32'(rx_bytes.size() - base), 10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < rx_bytes.size())
                check("fullpop_byte", 32'(rx_bytes[base + i]), (i == 9) ? 32'h5A : 32'(8'h10 + i));
        end

        // Mid-frame reset during data bit 3 with five bytes queued.
        for (int i = 0; i < 6; i++) begin
            out_data  = 8'(8'hC0 + i);
            out_valid = 1'b1;
            tick();
        end
        out_valid = 1'b0;
        repeat (13) tick();
        check("mid_count", 32'(count), 5);
        check("mid_busy", 32'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_tx", 32'(tx), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_ready", 32'(out_ready), 1);
        out_valid = 1'b1;
        clr_ovf   = 1'b1;
        tick();
        out_valid = 1'b0;
        clr_ovf   = 1'b0;
        check("rst_ignores_valid", 32'(count), 0);
        reset  = 1'b0;
        starts = rx_start.size();
        repeat (60) tick();
        check("post_rst_quiet", 32'(rx_start.size() - starts), 0);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_tx", 32'(tx), 1);

        // Wrap: 20 bytes in groups of 3 drain in write order.
        base = rx_bytes.size();
        idx  = 0;
        for (int g = 0; g < 7; g++) begin
            for (int j = 0; j < ((g == 6) ? 2 : 3); j++) begin
                out_data  = 8'(8'h30 + idx);
                out_valid = 1'b1;
                tick();
                idx = idx + 1;
            end
            out_valid = 1'b0;
            wait_idle(300, waited);
            check("wrap_count", 32'(count), 0);
        end
        check("wrap_frames", 32'(rx_bytes.size() - base), 20);
        for (int i = 0; i < 20; i++) begin
            if (base + i < rx_bytes.size()) check("wrap_byte", 32'(rx_bytes[base + i]), 32'(8'h30 + i));
        end
        check("frame_stop_bits", 32'(rx_ferr), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
